pipe_fde_regs: RTL and testbench
================================

Name: pipe_fde_regs

Overview:
- Receiving end of the pipeline hazard-control interface. Consumes the stall, flush and forward-select signals and applies them to the PC register, the F/D register and the D/E register.
- Drives the E-stage register addresses and mem_to_reg_e back to the hazard logic.
- Also implements the E-stage operand forwarding muxes and saturating stall/flush event counters.

Parameters:
PC_W, 8, program counter width
INSTR_W, 16, instruction width
DATA_W, 16, register/operand data width
CNT_W, 16, width of event counters

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
stall_f  in  1  hold PC
stall_d  in  1  hold F/D register
flush_d  in  1  clear F/D register to bubble
flush_e  in  1  clear D/E register to bubble
pc_source  in  1  taken branch resolved this cycle
pc_branch  in  PC_W  branch target
instr_f  in  INSTR_W  instruction fetched at pc_f
pc_f  out  PC_W  current PC
instr_d  out  INSTR_W  F/D instruction
pc_plus1_d  out  PC_W  F/D pc+1
valid_d  out  1  F/D holds a real instruction
reg_read_adr1_d, reg_read_adr2_d, reg_write_adr_d  in  3 each  decoded addresses
mem_to_reg_d, reg_write_d  in  1 each  decoded controls
rd1_d, rd2_d  in  DATA_W each  register-file read data
reg_read_adr1_e, reg_read_adr2_e, reg_write_adr_e  out  3 each  D/E addresses
mem_to_reg_e, reg_write_e, valid_e  out  1 each  D/E controls
forward1_e, forward2_e  in  2 each  operand select
alu_result_m  in  DATA_W  M-stage result
result_w  in  DATA_W  W-stage result
src_a_e, src_b_e  out  DATA_W  forwarded operands
stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Reset (async, reset_n=0): every register is 0.
  - Covers pc_f, instr_d, pc_plus1_d, valid_d, all D/E fields including rd1_e/rd2_e, and both counters.
  - src_a_e/src_b_e therefore read 0.
  - Reset applies immediately mid-operation.
  - First fetch after release is at PC 0.
- PC update, per edge, in priority order:
  1. pc_source=1: pc_f <= pc_branch. Overrides stall_f.
  2. Else stall_f=1: hold.
  3. Else pc_f <= pc_f+1, wrapping modulo 2^PC_W.
- F/D update, per edge, in priority order:
  1. flush_d=1: instr_d<=0, pc_plus1_d<=0, valid_d<=0. Overrides stall_d.
  2. Else stall_d=1: hold all fields.
  3. Else instr_d<=instr_f, pc_plus1_d<=pc_f+1 (wrapping), valid_d<=1.
- D/E update, per edge:
  - flush_e=1: insert a bubble. All D/E fields <=0, so reg_write_e=0, mem_to_reg_e=0, valid_e=0.
  - Else load all *_d inputs and rd1_d/rd2_d, with valid_e<=valid_d.
  - D/E never holds, so stall_d without flush_e would duplicate. Bench must treat that combination as illegal.
- Forward muxes (combinational from D/E state and inputs), applied to src_a_e (forward1_e, rd1_e) and src_b_e (forward2_e, rd2_e):
  - 0: register value.
  - 1: alu_result_m.
  - 2: result_w.
  - 3: register value (reserved).
- Latency:
  - Instruction at pc_f appears in instr_d 1 cycle later.
  - Its decoded fields appear on the E outputs 2 cycles later.
- stall_cnt: +1 on each edge with stall_d=1. Saturates at all-ones, no wrap.
- flush_cnt: +1 on each edge with flush_d=1 or flush_e=1, counting at most 1 per cycle. Saturates at all-ones.

Test Plan:
- Reset, then 3 free cycles with instr_f=16'hA000+pc -> pc_f=3, instr_d=16'hA002, pc_plus1_d=3, valid_d=1.
- Load-use: stall_f=stall_d=flush_e=1 for 1 cycle at pc_f=5 -> pc_f stays 5, instr_d held, valid_e=0, reg_write_e=0, stall_cnt=1, flush_cnt=1.
- Branch with simultaneous stall: pc_source=flush_d=stall_f=stall_d=1, pc_branch=8'h40 -> pc_f=8'h40, valid_d=0, stall_cnt+1, flush_cnt+1.
- Forwarding: rd1_e=16'h0011, alu_result_m=16'h2222, result_w=16'h3333; forward1_e=0,1,2,3 -> src_a_e=0011,2222,3333,0011. Same sweep on src_b_e.
- Wrap and saturate (CNT_W=2 build):
  - pc_f=8'hFF with no stall -> next pc_f=0, pc_plus1_d=0.
  - 5 stall cycles -> stall_cnt=3.
- reset_n pulsed low mid-stall between clock edges -> all outputs 0 immediately; PC 0 refetched after release.

Source files
------------

// File: rtl/pipe_fde_regs.sv
// Fetch/decode/execute pipeline registers driven by hazard control: PC, F/D and D/E
// registers, E-stage operand forwarding, and saturating stall/flush event counters.
module pipe_fde_regs #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_f,
    input  logic               stall_d,
    input  logic               flush_d,
    input  logic               flush_e,
    input  logic               pc_source,
    input  logic [PC_W-1:0]    pc_branch,
    input  logic [INSTR_W-1:0] instr_f,
    output logic [PC_W-1:0]    pc_f,
    output logic [INSTR_W-1:0] instr_d,
    output logic [PC_W-1:0]    pc_plus1_d,
    output logic               valid_d,
    input  logic [2:0]         reg_read_adr1_d,
    input  logic [2:0]         reg_read_adr2_d,
    input  logic [2:0]         reg_write_adr_d,
    input  logic               mem_to_reg_d,
    input  logic               reg_write_d,
    input  logic [DATA_W-1:0]  rd1_d,
    input  logic [DATA_W-1:0]  rd2_d,
    output logic [2:0]         reg_read_adr1_e,
    output logic [2:0]         reg_read_adr2_e,
    output logic [2:0]         reg_write_adr_e,
    output logic               mem_to_reg_e,
    output logic               reg_write_e,
    output logic               valid_e,
    input  logic [1:0]         forward1_e,
    input  logic [1:0]         forward2_e,
    input  logic [DATA_W-1:0]  alu_result_m,
    input  logic [DATA_W-1:0]  result_w,
    output logic [DATA_W-1:0]  src_a_e,
    output logic [DATA_W-1:0]  src_b_e,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [PC_W-1:0]    pc_q,        pc_d;
    logic [INSTR_W-1:0] fd_instr_q,  fd_instr_d;
    logic [PC_W-1:0]    fd_pc1_q,    fd_pc1_d;
    logic               fd_valid_q,  fd_valid_d;
    logic [2:0]         de_adr1_q,   de_adr1_d;
    logic [2:0]         de_adr2_q,   de_adr2_d;
    logic [2:0]         de_wadr_q,   de_wadr_d;
    logic               de_mtr_q,    de_mtr_d;
    logic               de_rw_q,     de_rw_d;
    logic               de_valid_q,  de_valid_d;
    logic [DATA_W-1:0]  de_rd1_q,    de_rd1_d;
    logic [DATA_W-1:0]  de_rd2_q,    de_rd2_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [PC_W-1:0]    pc_inc_s;

    assign pc_inc_s = pc_q + PC_W'(1);

    // Next-state for PC, F/D, D/E and counters; a branch beats a stall, a flush beats a stall.
    always_comb begin
        pc_d        = pc_q;
        fd_instr_d  = fd_instr_q;
        fd_pc1_d    = fd_pc1_q;
        fd_valid_d  = fd_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (pc_source) begin
            pc_d = pc_branch;
        end else if (!stall_f) begin
            pc_d = pc_inc_s;
        end else begin
            pc_d = pc_q;
        end

        if (flush_d) begin
            fd_instr_d = {INSTR_W{1'b0}};
            fd_pc1_d   = {PC_W{1'b0}};
            fd_valid_d = 1'b0;
        end else if (!stall_d) begin
            fd_instr_d = instr_f;
            fd_pc1_d   = pc_inc_s;
            fd_valid_d = 1'b1;
        end else begin
            fd_valid_d = fd_valid_q;
        end

        // D/E has no hold path: the hazard unit must pair stall_d with flush_e.
        if (flush_e) begin
            de_adr1_d  = 3'd0;
            de_adr2_d  = 3'd0;
            de_wadr_d  = 3'd0;
            de_mtr_d   = 1'b0;
            de_rw_d    = 1'b0;
            de_valid_d = 1'b0;
            de_rd1_d   = {DATA_W{1'b0}};
            de_rd2_d   = {DATA_W{1'b0}};
        end else begin
            de_adr1_d  = reg_read_adr1_d;
            de_adr2_d  = reg_read_adr2_d;
            de_wadr_d  = reg_write_adr_d;
            de_mtr_d   = mem_to_reg_d;
            de_rw_d    = reg_write_d;
            de_valid_d = fd_valid_q;
            de_rd1_d   = rd1_d;
            de_rd2_d   = rd2_d;
        end

        if (stall_d && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if ((flush_d || flush_e) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q        <= {PC_W{1'b0}};
            fd_instr_q  <= {INSTR_W{1'b0}};
            fd_pc1_q    <= {PC_W{1'b0}};
            fd_valid_q  <= 1'b0;
            de_adr1_q   <= 3'd0;
            de_adr2_q   <= 3'd0;
            de_wadr_q   <= 3'd0;
            de_mtr_q    <= 1'b0;
            de_rw_q     <= 1'b0;
            de_valid_q  <= 1'b0;
            de_rd1_q    <= {DATA_W{1'b0}};
            de_rd2_q    <= {DATA_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc_q        <= pc_d;
            fd_instr_q  <= fd_instr_d;
            fd_pc1_q    <= fd_pc1_d;
            fd_valid_q  <= fd_valid_d;
            de_adr1_q   <= de_adr1_d;
            de_adr2_q   <= de_adr2_d;
            de_wadr_q   <= de_wadr_d;
            de_mtr_q    <= de_mtr_d;
            de_rw_q     <= de_rw_d;
            de_valid_q  <= de_valid_d;
            de_rd1_q    <= de_rd1_d;
            de_rd2_q    <= de_rd2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Operand forwarding; select 3 is reserved and falls back to the register value.
    always_comb begin
        src_a_e = de_rd1_q;
        src_b_e = de_rd2_q;
        case (forward1_e)
            2'd1:    src_a_e = alu_result_m;
            2'd2:    src_a_e = result_w;
            default: src_a_e = de_rd1_q;
        endcase
        case (forward2_e)
            2'd1:    src_b_e = alu_result_m;
            2'd2:    src_b_e = result_w;
            default: src_b_e = de_rd2_q;
        endcase
    end

    assign pc_f            = pc_q;
    assign instr_d         = fd_instr_q;
    assign pc_plus1_d      = fd_pc1_q;
    assign valid_d         = fd_valid_q;
    assign reg_read_adr1_e = de_adr1_q;
    assign reg_read_adr2_e = de_adr2_q;
    assign reg_write_adr_e = de_wadr_q;
    assign mem_to_reg_e    = de_mtr_q;
    assign reg_write_e     = de_rw_q;
    assign valid_e         = de_valid_q;
    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_pipe_fde_regs.sv
// Scoreboard bench for pipe_fde_regs (built with CNT_W=2 so counter saturation is reachable).
module tb_pipe_fde_regs;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
        logic [7:0]  pp1;
        logic        vd;
        logic [2:0]  a1, a2, aw;
        logic        mtr, rw, ve;
        logic [15:0] rd1, rd2;
        logic [1:0]  sc, fc;
    } st_t;

    typedef struct packed {
        st_t         st;
        logic [15:0] sa, sb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_f, stall_d, flush_d, flush_e, pc_source;
    logic [7:0]  pc_branch;
    logic [15:0] instr_f;
    logic [7:0]  pc_f, pc_plus1_d;
    logic [15:0] instr_d;
    logic        valid_d;
    logic [2:0]  reg_read_adr1_d, reg_read_adr2_d, reg_write_adr_d;
    logic        mem_to_reg_d, reg_write_d;
    logic [15:0] rd1_d, rd2_d;
    logic [2:0]  reg_read_adr1_e, reg_read_adr2_e, reg_write_adr_e;
    logic        mem_to_reg_e, reg_write_e, valid_e;
    logic [1:0]  forward1_e, forward2_e;
    logic [15:0] alu_result_m, result_w, src_a_e, src_b_e;
    logic [1:0]  stall_cnt, flush_cnt;

    st_t   m;
    exp_t  exp_q[$];
    exp_t  e;
    event  chk_ev;
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    pipe_fde_regs #(.PC_W(8), .INSTR_W(16), .DATA_W(16), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .pc_source(pc_source), .pc_branch(pc_branch), .instr_f(instr_f),
        .pc_f(pc_f), .instr_d(instr_d), .pc_plus1_d(pc_plus1_d), .valid_d(valid_d),
        .reg_read_adr1_d(reg_read_adr1_d), .reg_read_adr2_d(reg_read_adr2_d),
        .reg_write_adr_d(reg_write_adr_d), .mem_to_reg_d(mem_to_reg_d), .reg_write_d(reg_write_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d),
        .reg_read_adr1_e(reg_read_adr1_e), .reg_read_adr2_e(reg_read_adr2_e),
        .reg_write_adr_e(reg_write_adr_e), .mem_to_reg_e(mem_to_reg_e),
        .reg_write_e(reg_write_e), .valid_e(valid_e),
        .forward1_e(forward1_e), .forward2_e(forward2_e),
        .alu_result_m(alu_result_m), .result_w(result_w),
        .src_a_e(src_a_e), .src_b_e(src_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [15:0] fwd(input logic [1:0] sel, input logic [15:0] r);
        case (sel)
            2'd1:    return alu_result_m;
            2'd2:    return result_w;
            default: return r;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic push_exp();
        exp_t x;
        x.st = m;
        x.sa = fwd(forward1_e, m.rd1);
        x.sb = fwd(forward2_e, m.rd2);
        exp_q.push_back(x);
    endtask

    // One clock: compute expected next state from current inputs, then let the edge happen.
    task automatic tick();
        st_t n;
        instr_f         = 16'hA000 + {8'h00, m.pc};
        reg_read_adr1_d = m.pc[2:0];
        reg_read_adr2_d = m.pc[2:0] + 3'd1;
        reg_write_adr_d = m.pc[2:0] + 3'd2;
        mem_to_reg_d    = m.pc[0];
        reg_write_d     = 1'b1;
        n = m;
        if (pc_source)     n.pc = pc_branch;
        else if (!stall_f) n.pc = m.pc + 8'd1;
        if (flush_d) begin
            n.instr = 16'h0000; n.pp1 = 8'h00; n.vd = 1'b0;
        end else if (!stall_d) begin
            n.instr = instr_f; n.pp1 = m.pc + 8'd1; n.vd = 1'b1;
        end
        if (flush_e) begin
            n.a1 = 3'd0; n.a2 = 3'd0; n.aw = 3'd0; n.mtr = 1'b0; n.rw = 1'b0; n.ve = 1'b0;
            n.rd1 = 16'h0000; n.rd2 = 16'h0000;
        end else begin
            n.a1 = reg_read_adr1_d; n.a2 = reg_read_adr2_d; n.aw = reg_write_adr_d;
            n.mtr = mem_to_reg_d; n.rw = reg_write_d; n.ve = m.vd;
            n.rd1 = rd1_d; n.rd2 = rd2_d;
        end
        if (stall_d && m.sc != 2'd3) n.sc = m.sc + 2'd1;
        if ((flush_d || flush_e) && m.fc != 2'd3) n.fc = m.fc + 2'd1;
        @(posedge clk);
        m = n;
        push_exp();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic sf, input logic sd, input logic fd, input logic fe, input logic ps);
        stall_f = sf; stall_d = sd; flush_d = fd; flush_e = fe; pc_source = ps;
    endtask

    // Monitor: compares every queued expectation at the falling edge or on an explicit probe.
    always begin
        @(negedge clk or chk_ev);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_f",            {8'h00, pc_f},            {8'h00, e.st.pc});
            chk("instr_d",         instr_d,                  e.st.instr);
            chk("pc_plus1_d",      {8'h00, pc_plus1_d},      {8'h00, e.st.pp1});
            chk("valid_d",         {15'h0, valid_d},         {15'h0, e.st.vd});
            chk("reg_read_adr1_e", {13'h0, reg_read_adr1_e}, {13'h0, e.st.a1});
            chk("reg_read_adr2_e", {13'h0, reg_read_adr2_e}, {13'h0, e.st.a2});
            chk("reg_write_adr_e", {13'h0, reg_write_adr_e}, {13'h0, e.st.aw});
            chk("mem_to_reg_e",    {15'h0, mem_to_reg_e},    {15'h0, e.st.mtr});
            chk("reg_write_e",     {15'h0, reg_write_e},     {15'h0, e.st.rw});
            chk("valid_e",         {15'h0, valid_e},         {15'h0, e.st.ve});
            chk("src_a_e",         src_a_e,                  e.sa);
            chk("src_b_e",         src_b_e,                  e.sb);
            chk("stall_cnt",       {14'h0, stall_cnt},       {14'h0, e.st.sc});
            chk("flush_cnt",       {14'h0, flush_cnt},       {14'h0, e.st.fc});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pc_branch = 8'h00; instr_f = 16'hA000;
        reg_read_adr1_d = 3'd0; reg_read_adr2_d = 3'd0; reg_write_adr_d = 3'd0;
        mem_to_reg_d = 1'b0; reg_write_d = 1'b0;
        rd1_d = 16'h5A5A; rd2_d = 16'hC3C3;
        forward1_e = 2'd0; forward2_e = 2'd0;
        alu_result_m = 16'h2222; result_w = 16'h3333;
        m = '0;
        #12;
        push_exp();
        -> chk_ev;
        #1 reset_n = 1'b1;

        // Three free cycles: pc_f=3, instr_d=A002, pc_plus1_d=3
        repeat (3) tick();
        repeat (2) tick();

        // Load-use bubble at pc_f=5
        set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();

        // Taken branch with simultaneous stall
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        pc_branch = 8'h40;
        tick();

        // Forwarding sweep on both operands
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd1_d = 16'h0011; rd2_d = 16'h0044;
        for (int k = 0; k < 4; k++) begin
            forward1_e = 2'(k);
            forward2_e = 2'(3 - k);
            tick();
        end
        forward1_e = 2'd0; forward2_e = 2'd0;

        // PC wrap from FF to 00
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pc_branch = 8'hFF;
        tick();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Five stalls saturate the 2-bit counters
        set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();

        // Asynchronous reset pulse between edges while stalled
        reset_n = 1'b0;
        #1;
        m = '0;
        push_exp();
        -> chk_ev;
        #1 reset_n = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rd1_d = 16'h0BAD; rd2_d = 16'h0FEE;
        repeat (3) tick();

        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
